// File: rtl/store_merge.sv
// Narrows sw/sh/sb stores and merges sub-words into a word-wide memory by read-modify-write.
// Build option STORE_BE_EN: adds mem_be; sub-word stores then write directly with replicated lanes.
module store_merge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        StoreOp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
`ifdef STORE_BE_EN
  output logic [3:0]        mem_be,
`endif
  output logic              done,
  output logic              err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] MERGE = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;

  logic [1:0]  state;
  logic [1:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] sub_q;
  logic        accept;
  logic        reject;
  logic [31:0] merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    reject = 1'b0;
    case (StoreOp)
      OP_SW:   reject = (req_addr[1:0] != 2'b00);
      OP_SH:   reject = req_addr[0];
      OP_SB:   reject = 1'b0;
      default: reject = 1'b1;
    endcase
  end

  // Only the addressed lane(s) come from the store; the rest is the word just read.
  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB) merged[{off_q, 3'b000} +: 8] = sub_q[7:0];
    else               merged[{off_q[1], 4'b0000} +: 16] = sub_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      op_q      <= OP_SW;
      off_q     <= 2'b00;
      sub_q     <= '0;
`ifdef STORE_BE_EN
      mem_be    <= 4'b0000;
`endif
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            op_q      <= StoreOp;
            off_q     <= req_addr[1:0];
            sub_q     <= req_wdata[15:0];
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            if (reject) begin
              // WRITE without a strobe doubles as the one-cycle error response.
              state <= WRITE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (StoreOp == OP_SW) begin
              state     <= WRITE;
              mem_wr_en <= 1'b1;
              mem_wdata <= req_wdata;
              done      <= 1'b1;
`ifdef STORE_BE_EN
              mem_be    <= 4'b1111;
`endif
            end else begin
`ifdef STORE_BE_EN
              state     <= WRITE;
              mem_wr_en <= 1'b1;
              done      <= 1'b1;
              if (StoreOp == OP_SB) begin
                mem_wdata <= {4{req_wdata[7:0]}};
                mem_be    <= 4'b0001 << req_addr[1:0];
              end else begin
                mem_wdata <= {2{req_wdata[15:0]}};
                mem_be    <= req_addr[1] ? 4'b1100 : 4'b0011;
              end
`else
              state     <= READ;
              mem_rd_en <= 1'b1;
`endif
            end
          end
        end
        READ: begin
          state <= MERGE;
        end
        MERGE: begin
          state     <= WRITE;
          mem_wdata <= merged;
          mem_wr_en <= 1'b1;
          done      <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge.sv
// Self-checking bench for store_merge: directed test-plan cases plus randomized stores against a byte-lane memory model.
`timescale 1ns/1ps
module tb_store_merge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  StoreOp = 2'b00;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;
  logic [3:0]  be_eff;
`ifdef STORE_BE_EN
  logic [3:0]  mem_be;
  localparam bit BE_BUILD = 1'b1;
  assign be_eff = mem_be;
`else
  localparam bit BE_BUILD = 1'b0;
  assign be_eff = 4'hF;
`endif

  store_merge #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .StoreOp(StoreOp),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
`ifdef STORE_BE_EN
    .mem_be(mem_be),
`endif
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Word memory with one-cycle read latency.
  logic [31:0] memw [16];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= memw[mem_addr[5:2]];
    if (mem_wr_en)
      for (int i = 0; i < 4; i++)
        if (be_eff[i]) memw[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  int wr_cnt = 0;
  int overlap_cnt = 0;
  always @(negedge clk) begin
    if (mem_wr_en) wr_cnt++;
    if (mem_rd_en && mem_wr_en) overlap_cnt++;
  end

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [16];

  function automatic logic [31:0] ref_word(input logic [31:0] old, input logic [1:0] op,
                                           input logic [5:0] a, input logic [31:0] d);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    case (op)
      2'b00: for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
      2'b01: begin b[2*a[1]] = d[7:0]; b[2*a[1]+1] = d[15:8]; end
      2'b10: b[a[1:0]] = d[7:0];
      default: ;
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic bit ref_reject(input logic [1:0] op, input logic [5:0] a);
    return (op == 2'b11) || (op == 2'b00 && a[1:0] != 2'b00) || (op == 2'b01 && a[0]);
  endfunction

  function automatic logic [31:0] ref_lanes(input logic [1:0] op, input logic [31:0] d);
    if (op == 2'b10) return {4{d[7:0]}};
    if (op == 2'b01) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] op, input logic [5:0] a);
    if (op == 2'b10) return 4'(1 << a[1:0]);
    if (op == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Observations of the last store, filled in by do_store.
  int          rd_cyc, wr_cyc, done_cyc;
  logic        got_err, rdy_at_done, rdy_after;
  logic [31:0] wr_data, wr_addr, rd_addr;
  logic [3:0]  wr_be;
  time         acc_t;

  // Must be called at a negedge; returns at a negedge one cycle after done.
  task automatic do_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    int w;
    rd_cyc = 0; wr_cyc = 0; done_cyc = 0; got_err = 1'b0;
    rdy_at_done = 1'bx; wr_data = '0; wr_addr = '0; rd_addr = '0; wr_be = '0;
    req_valid = 1'b1; req_addr = a; req_wdata = d; StoreOp = op;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, w);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_t = $time;
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; StoreOp = 2'($urandom);
    if (!ref_reject(op, a[5:0])) ref_mem[a[5:2]] = ref_word(ref_mem[a[5:2]], op, a[5:0], d);
    for (int k = 1; k <= 8 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (mem_rd_en && rd_cyc == 0) begin rd_cyc = k; rd_addr = mem_addr; end
      if (mem_wr_en && wr_cyc == 0) begin
        wr_cyc = k; wr_addr = mem_addr; wr_data = mem_wdata; wr_be = be_eff;
      end
      if (done) begin done_cyc = k; got_err = err; rdy_at_done = req_ready; end
    end
    @(negedge clk);
    rdy_after = req_ready;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({req_ready, mem_rd_en, mem_wr_en, done, err} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: rdy/rd/wr/done/err=%b, required 10000",
               {req_ready, mem_rd_en, mem_wr_en, done, err});
    end
    tests++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      fails++;
      $display("FAIL reset_data: mem_addr=%h mem_wdata=%h, required 0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_sw();
    do_store(2'b00, 32'h10, 32'hDEADBEEF);
    tests++;
    if ({rd_cyc, wr_cyc, done_cyc} !== {32'd0, 32'd1, 32'd1} || got_err !== 1'b0) begin
      fails++;
      $display("FAIL sw_timing: rd=%0d wr=%0d done=%0d err=%b, required 0/1/1/0",
               rd_cyc, wr_cyc, done_cyc, got_err);
    end
    tests++;
    if (wr_addr !== 32'h10 || wr_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_data: addr=%h data=%h, required 00000010/deadbeef", wr_addr, wr_data);
    end
    tests++;
    if ({rdy_at_done, rdy_after} !== 2'b01) begin
      fails++;
      $display("FAIL sw_ready: ready at done/after=%b, required 01", {rdy_at_done, rdy_after});
    end
  endtask

  task automatic test_sb();
    logic [31:0] exp_d;
    do_store(2'b00, 32'h4, 32'h11223344);
    do_store(2'b10, 32'h7, 32'h000000AB);
`ifdef STORE_BE_EN
    exp_d = 32'hABABABAB;
    tests++;
    if ({rd_cyc, wr_cyc} !== {32'd0, 32'd1} || wr_be !== 4'b1000) begin
      fails++;
      $display("FAIL sb_be: rd=%0d wr=%0d be=%b, required 0/1/1000", rd_cyc, wr_cyc, wr_be);
    end
`else
    exp_d = 32'hAB223344;
    tests++;
    if ({rd_cyc, wr_cyc, done_cyc} !== {32'd1, 32'd3, 32'd3} || rd_addr !== 32'h4) begin
      fails++;
      $display("FAIL sb_timing: rd=%0d wr=%0d done=%0d rd_addr=%h, required 1/3/3/00000004",
               rd_cyc, wr_cyc, done_cyc, rd_addr);
    end
`endif
    tests++;
    if (wr_addr !== 32'h4 || wr_data !== exp_d) begin
      fails++;
      $display("FAIL sb_data: addr=%h data=%h, required 00000004/%h", wr_addr, wr_data, exp_d);
    end
    tests++;
    if (memw[1] !== 32'hAB223344) begin
      fails++;
      $display("FAIL sb_mem: word=%h, required ab223344", memw[1]);
    end
  endtask

  task automatic test_sh();
    do_store(2'b00, 32'h0, 32'h11223344);
    do_store(2'b01, 32'h2, 32'h0000CAFE);
    tests++;
    if (wr_data !== (BE_BUILD ? 32'hCAFECAFE : 32'hCAFE3344) || got_err !== 1'b0) begin
      fails++;
      $display("FAIL sh_data: data=%h err=%b, required %h/0", wr_data, got_err,
               BE_BUILD ? 32'hCAFECAFE : 32'hCAFE3344);
    end
    tests++;
    if (memw[0] !== 32'hCAFE3344) begin
      fails++;
      $display("FAIL sh_mem: word=%h, required cafe3344", memw[0]);
    end
  endtask

  task automatic test_reject();
    logic [1:0]  ops [2];
    logic [31:0] adrs [2];
    ops[0] = 2'b00; adrs[0] = 32'h6;
    ops[1] = 2'b11; adrs[1] = 32'h8;
    for (int i = 0; i < 2; i++) begin
      do_store(ops[i], adrs[i], $urandom);
      tests++;
      if ({rd_cyc, wr_cyc, done_cyc} !== {32'd0, 32'd0, 32'd1} || got_err !== 1'b1) begin
        fails++;
        $display("FAIL reject_%0d: rd=%0d wr=%0d done=%0d err=%b, required 0/0/1/1",
                 i, rd_cyc, wr_cyc, done_cyc, got_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    time t1;
    do_store(2'b00, 32'h0, 32'h0);
    do_store(2'b10, 32'h0, 32'h55);
    t1 = acc_t;
    tests++;
    if (rdy_at_done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_busy: req_ready at done=%b, required 0", rdy_at_done);
    end
    do_store(2'b10, 32'h1, 32'h66);
    tests++;
    if (acc_t - t1 !== (BE_BUILD ? 64'd20 : 64'd40)) begin
      fails++;
      $display("FAIL b2b_gap: accept spacing=%0t, required %0d", acc_t - t1, BE_BUILD ? 20 : 40);
    end
    tests++;
    if (memw[0] !== 32'h00006655) begin
      fails++;
      $display("FAIL b2b_mem: word=%h, required 00006655", memw[0]);
    end
  endtask

`ifndef STORE_BE_EN
  task automatic test_reset_midop();
    int w0;
    do_store(2'b00, 32'h20, 32'hA5A5A5A5);
    req_valid = 1'b1; req_addr = 32'h21; req_wdata = 32'h99; StoreOp = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL midop_read: mem_rd_en=%b, required 1", mem_rd_en);
    end
    w0 = wr_cnt;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({req_ready, mem_rd_en, mem_wr_en, done} !== 4'b1000) begin
      fails++;
      $display("FAIL midop_reset: rdy/rd/wr/done=%b, required 1000",
               {req_ready, mem_rd_en, mem_wr_en, done});
    end
    repeat (4) @(negedge clk);
    tests++;
    if (wr_cnt !== w0 || memw[8] !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL midop_nowrite: writes=%0d word=%h, required 0/a5a5a5a5", wr_cnt - w0, memw[8]);
    end
  endtask
`endif

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, d, exp_w, exp_d;
    bit          rej, sub;
    int          e_rd, e_wr, e_done;
    for (int i = 0; i < 16; i++) do_store(2'b00, 32'(i * 4), $urandom);
    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(3, 0));
      a  = 32'($urandom_range(63, 0));
      d  = $urandom;
      rej = ref_reject(op, a[5:0]);
      sub = (op == 2'b01 || op == 2'b10) && !BE_BUILD;
      exp_w = ref_word(ref_mem[a[5:2]], op, a[5:0], d);
      exp_d = BE_BUILD ? ref_lanes(op, d) : exp_w;
      e_rd   = (!rej && sub) ? 1 : 0;
      e_wr   = rej ? 0 : (sub ? 3 : 1);
      e_done = (!rej && sub) ? 3 : 1;
      do_store(op, a, d);
      tests++;
      if ({rd_cyc, wr_cyc, done_cyc} !== {e_rd, e_wr, e_done} || got_err !== rej) begin
        fails++;
        $display("FAIL rnd_timing #%0d op=%b a=%h: rd=%0d wr=%0d done=%0d err=%b, required %0d/%0d/%0d/%b",
                 n, op, a, rd_cyc, wr_cyc, done_cyc, got_err, e_rd, e_wr, e_done, rej);
      end
      if (!rej) begin
        tests++;
        if (wr_addr !== {a[31:2], 2'b00} || wr_data !== exp_d) begin
          fails++;
          $display("FAIL rnd_write #%0d op=%b a=%h: addr=%h data=%h, required %h/%h",
                   n, op, a, wr_addr, wr_data, {a[31:2], 2'b00}, exp_d);
        end
`ifdef STORE_BE_EN
        tests++;
        if (wr_be !== ref_be(op, a[5:0])) begin
          fails++;
          $display("FAIL rnd_be #%0d: be=%b, required %b", n, wr_be, ref_be(op, a[5:0]));
        end
`endif
      end
      if (e_rd != 0) begin
        tests++;
        if (rd_addr !== wr_addr) begin
          fails++;
          $display("FAIL rnd_addr_hold #%0d: read addr=%h write addr=%h, required equal", n, rd_addr, wr_addr);
        end
      end
      tests++;
      if (memw[a[5:2]] !== ref_mem[a[5:2]]) begin
        fails++;
        $display("FAIL rnd_mem #%0d word %0d: %h, required %h", n, a[5:2], memw[a[5:2]], ref_mem[a[5:2]]);
      end
    end
    tests++;
    if (overlap_cnt !== 0) begin
      fails++;
      $display("FAIL strobe_overlap: %0d cycles with rd and wr, required 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_reject();
    test_back_to_back();
`ifndef STORE_BE_EN
    test_reset_midop();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

endmodule

// File: doc/store_merge.md
Name: store_merge

Overview:
- Write-side counterpart of the datapath's load/immediate widening path: narrows a 32-bit store operand to byte/halfword and merges it into a word-wide data memory that has no byte enables.
- Sits between the EX/MEM stage store request and the data memory.
- Sub-word stores use a read-modify-write (RMW) sequence.
- Word stores are written directly.

Parameters:
- ADDR_W, 32, byte-address width; the memory word address is addr[ADDR_W-1:2].

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- req_valid  input  1  store request valid
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_addr  input  ADDR_W  byte address of the store
- req_wdata  input  32  store data; sb uses [7:0], sh uses [15:0]
- StoreOp  input  2  00 sw, 01 sh, 10 sb, 11 reserved
- mem_addr  output  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- mem_rd_en  output  1  memory read strobe; mem_rdata is valid the next cycle
- mem_rdata  input  32  memory read data
- mem_wr_en  output  1  memory write strobe
- mem_wdata  output  32  full word to write
- done  output  1  one-cycle pulse: store completed or rejected
- err  output  1  qualifies done: request rejected, nothing written

Behaviour:
- States: IDLE, READ, MERGE, WRITE. All outputs are registered.
- Reset (reset==0 at a clk edge): state=IDLE; mem_rd_en=0, mem_wr_en=0, done=0, err=0; mem_addr=0, mem_wdata=0; req_ready=1 once reset is released.
- Reset mid-operation aborts the store and no write is issued.
- Acceptance: a request is accepted on a clk edge where req_valid & req_ready. At acceptance the unit latches addr, wdata and StoreOp, and req_ready drops the next cycle.
- Alignment check at acceptance:
  - sw needs addr[1:0]==00.
  - sh needs addr[0]==0.
  - sb is always aligned.
  - StoreOp 11 is always rejected.
- Rejected request: next cycle done=1, err=1; no memory strobe; back to IDLE.
- sw (accepted at edge N): state WRITE during cycle N+1 with mem_wr_en=1, mem_wdata=wdata, done=1. IDLE at N+2.
- sb/sh, cycle by cycle after acceptance at edge N:
  - READ in cycle N+1: mem_rd_en=1.
  - MERGE in cycle N+2: mem_rdata valid; merged word registered.
  - WRITE in cycle N+3: mem_wr_en=1, done=1.
  - IDLE at N+4.
- Merge rule (little-endian, lane k = bits 8k+7:8k):
  - sb replaces lane addr[1:0] with wdata[7:0].
  - sh replaces bits 16h+15:16h (h=addr[1]) with wdata[15:0].
  - All other bits come from mem_rdata.
- Strobe exclusivity: mem_rd_en and mem_wr_en are never high in the same cycle.
- Address hold: mem_addr is held constant from READ through WRITE.
- Input changes: req_* changes after acceptance have no effect.
- Back-to-back: a new request is accepted in the IDLE cycle right after done. There is no overlap, so RMW ordering is naturally preserved.

Optional Feature:
- Macro: STORE_BE_EN.
- When defined:
  - Adds output port mem_be [3:0].
  - sb/sh skip READ/MERGE and go directly to WRITE, with the same timing as sw.
  - mem_wdata carries the byte/halfword replicated across lanes: sb {4{b}}, sh {2{h}}.
  - mem_be: sw 1111; sh 0011 or 1100 by addr[1]; sb one-hot 1<<addr[1:0].
  - Alignment and error rules are unchanged.
- When undefined: no mem_be port; RMW behaviour as above.

Test Plan:
- reset=0 for 2 cycles during a READ -> next cycle mem_rd_en=0, mem_wr_en=0, done=0, req_ready=1; no write occurs.
- sw addr 0x00000010, wdata 0xDEADBEEF -> one cycle later mem_wr_en=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, done=1, err=0.
- sb addr 0x00000007, wdata 0x000000AB, mem_rdata 0x11223344 -> mem_rd_en at +1; at +3 mem_wr_en=1, mem_addr=0x04, mem_wdata=0xAB223344.
- sh addr 0x00000002, wdata 0x0000CAFE, mem_rdata 0x11223344 -> at +3 mem_wdata=0xCAFE3344.
- sw addr 0x00000006 and StoreOp=11 -> each gives done=1, err=1 one cycle later; mem_wr_en and mem_rd_en stay 0.
- Back-to-back sb to 0x0 then sb to 0x1 (wdata 0x55, then 0x66; memory model initially 0x00000000) -> final memory word 0x00006655; second request accepted only after the first done.
- STORE_BE_EN build: sb addr 0x2, wdata 0x77 -> single cycle write, mem_be=0100, mem_wdata=0x77777777, no mem_rd_en.
